// File: rtl/fiber_mshr_if.sv
// Handshake bundle for fiber_mshr: bank miss in, memory request/response,
// fill back to the bank, plus occupancy and statistics outputs.
interface fiber_mshr_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 64,
    parameter int PRIORITY_BITS = 5,
    parameter int ENTRIES       = 8,
    parameter int CNT_BITS      = 3,
    parameter int ID_W          = $clog2(ENTRIES)
);
    logic                     i_miss_valid;
    logic                     o_miss_ready;
    logic [ADDR_WIDTH-1:0]    i_miss_addr;
    logic [PRIORITY_BITS-1:0] i_miss_prio;

    logic                     o_mem_req_valid;
    logic                     i_mem_req_ready;
    logic [ADDR_WIDTH-1:0]    o_mem_req_addr;
    logic [ID_W-1:0]          o_mem_req_id;

    logic                     i_mem_resp_valid;
    logic [ID_W-1:0]          i_mem_resp_id;
    logic [DATA_WIDTH-1:0]    i_mem_resp_data;

    logic                     o_fill_valid;
    logic                     i_fill_ready;
    logic [ADDR_WIDTH-1:0]    o_fill_addr;
    logic [DATA_WIDTH-1:0]    o_fill_data;
    logic [PRIORITY_BITS-1:0] o_fill_prio;
    logic [CNT_BITS-1:0]      o_fill_count;

    logic [ID_W:0]            o_occupancy;
    logic [31:0]              o_stat_allocs;
    logic [31:0]              o_stat_merges;

    // MSHR side
    modport slave (
        input  i_miss_valid, i_miss_addr, i_miss_prio,
        output o_miss_ready,
        output o_mem_req_valid, o_mem_req_addr, o_mem_req_id,
        input  i_mem_req_ready,
        input  i_mem_resp_valid, i_mem_resp_id, i_mem_resp_data,
        output o_fill_valid, o_fill_addr, o_fill_data,
        output o_fill_prio, o_fill_count,
        input  i_fill_ready,
        output o_occupancy, o_stat_allocs, o_stat_merges
    );

    // Bank / memory side
    modport master (
        output i_miss_valid, i_miss_addr, i_miss_prio,
        input  o_miss_ready,
        input  o_mem_req_valid, o_mem_req_addr, o_mem_req_id,
        output i_mem_req_ready,
        output i_mem_resp_valid, i_mem_resp_id, i_mem_resp_data,
        input  o_fill_valid, o_fill_addr, o_fill_data,
        input  o_fill_prio, o_fill_count,
        output i_fill_ready,
        input  o_occupancy, o_stat_allocs, o_stat_merges
    );
endinterface

// File: rtl/fiber_mshr.sv
// Miss-status holding registers behind fiberBank: merges same-line misses,
// one memory read per line, fills carry waiter count and max priority.
// Optional counters: define FIBER_MSHR_STATS_EN for alloc/merge statistics.
module fiber_mshr #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 64,
    parameter int OFFSET_BITS   = 1,
    parameter int PRIORITY_BITS = 5,
    parameter int ENTRIES       = 8,
    parameter int CNT_BITS      = 3,
    parameter int ID_W          = $clog2(ENTRIES)
) (
    input logic          i_clk,
    input logic          i_rst_n,
    fiber_mshr_if.slave  bus
);
    typedef enum logic [1:0] {
        FREE,
        PENDING,
        ISSUED,
        FILLED
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

    state_e                   st_q   [ENTRIES];
    state_e                   st_d   [ENTRIES];
    logic [ADDR_WIDTH-1:0]    addr_q [ENTRIES];
    logic [ADDR_WIDTH-1:0]    addr_d [ENTRIES];
    logic [PRIORITY_BITS-1:0] prio_q [ENTRIES];
    logic [PRIORITY_BITS-1:0] prio_d [ENTRIES];
    logic [CNT_BITS-1:0]      cnt_q  [ENTRIES];
    logic [CNT_BITS-1:0]      cnt_d  [ENTRIES];
    logic [DATA_WIDTH-1:0]    data_q [ENTRIES];
    logic [DATA_WIDTH-1:0]    data_d [ENTRIES];

    logic            rhold_q, rhold_d;
    logic [ID_W-1:0] rhold_id_q, rhold_id_d;
    logic            fhold_q, fhold_d;
    logic [ID_W-1:0] fhold_id_q, fhold_id_d;

    logic [ADDR_WIDTH-1:0] miss_line;
    logic                  hit;
    logic [ID_W-1:0]       hit_id;
    logic                  any_free;
    logic [ID_W-1:0]       free_id;
    logic                  miss_ready;
    logic                  miss_fire;

    logic                     pend_any;
    logic [ID_W-1:0]          pend_sel;
    logic [PRIORITY_BITS-1:0] pend_best;
    logic                     req_valid;
    logic [ID_W-1:0]          req_id;
    logic                     req_fire;

    logic                  resp_ok;
    logic                  fl_any;
    logic [ID_W-1:0]       fl_sel;
    logic                  fill_valid;
    logic [ID_W-1:0]       fill_id;
    logic                  fill_fire;
    logic [ID_W:0]         occ;

    assign miss_line = bus.i_miss_addr & ~OFF_MASK;

    // Line match against in-flight entries and lowest free slot
    always_comb begin
        hit      = 1'b0;
        hit_id   = '0;
        any_free = 1'b0;
        free_id  = '0;
        occ      = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((st_q[i] == PENDING || st_q[i] == ISSUED) &&
                addr_q[i] == miss_line) begin
                hit    = 1'b1;
                hit_id = ID_W'(i);
            end
            if (st_q[i] == FREE) begin
                any_free = 1'b1;
                free_id  = ID_W'(i);
            end else begin
                occ = occ + 1'b1;
            end
        end
    end

    assign miss_ready = i_rst_n &
                        (hit ? ~&cnt_q[hit_id] : any_free);
    assign miss_fire  = bus.i_miss_valid & miss_ready;

    // Issue pick: highest priority PENDING, ties to lowest index
    always_comb begin
        pend_any  = 1'b0;
        pend_sel  = '0;
        pend_best = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (st_q[i] == PENDING &&
                (!pend_any || prio_q[i] > pend_best)) begin
                pend_any  = 1'b1;
                pend_sel  = ID_W'(i);
                pend_best = prio_q[i];
            end
        end
    end

    // A stalled request keeps its entry; otherwise follow the live pick
    assign req_id    = rhold_q ? rhold_id_q : pend_sel;
    assign req_valid = rhold_q | pend_any;
    assign req_fire  = req_valid & bus.i_mem_req_ready;

    assign resp_ok = bus.i_mem_resp_valid &
                     (st_q[bus.i_mem_resp_id] == ISSUED);

    // Fill pick: lowest-index FILLED entry
    always_comb begin
        fl_any = 1'b0;
        fl_sel = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (st_q[i] == FILLED) begin
                fl_any = 1'b1;
                fl_sel = ID_W'(i);
            end
        end
    end

    assign fill_id    = fhold_q ? fhold_id_q : fl_sel;
    assign fill_valid = fhold_q | fl_any;
    assign fill_fire  = fill_valid & bus.i_fill_ready;

    // Entry next-state: allocate/merge, issue, response, fill release
    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rhold_d    = req_valid & ~bus.i_mem_req_ready;
        rhold_id_d = req_id;
        fhold_d    = fill_valid & ~bus.i_fill_ready;
        fhold_id_d = fill_id;
        if (miss_fire) begin
            if (hit) begin
                cnt_d[hit_id] = cnt_q[hit_id] + 1'b1;
                if (bus.i_miss_prio > prio_q[hit_id]) begin
                    prio_d[hit_id] = bus.i_miss_prio;
                end
            end else begin
                st_d[free_id]   = PENDING;
                addr_d[free_id] = miss_line;
                prio_d[free_id] = bus.i_miss_prio;
                cnt_d[free_id]  = CNT_BITS'(1);
            end
        end
        if (req_fire) begin
            st_d[req_id] = ISSUED;
        end
        if (resp_ok) begin
            st_d[bus.i_mem_resp_id]   = FILLED;
            data_d[bus.i_mem_resp_id] = bus.i_mem_resp_data;
        end
        if (fill_fire) begin
            st_d[fill_id] = FREE;
        end
    end

    // Entry and handshake-hold registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= '{default: FREE};
            addr_q     <= '{default: '0};
            prio_q     <= '{default: '0};
            cnt_q      <= '{default: '0};
            data_q     <= '{default: '0};
            rhold_q    <= 1'b0;
            rhold_id_q <= '0;
            fhold_q    <= 1'b0;
            fhold_id_q <= '0;
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rhold_q    <= rhold_d;
            rhold_id_q <= rhold_id_d;
            fhold_q    <= fhold_d;
            fhold_id_q <= fhold_id_d;
        end
    end

    assign bus.o_miss_ready    = miss_ready;
    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_req_id    = req_id;
    assign bus.o_mem_req_addr  = addr_q[req_id];
    assign bus.o_fill_valid    = fill_valid;
    assign bus.o_fill_addr     = addr_q[fill_id];
    assign bus.o_fill_data     = data_q[fill_id];
    assign bus.o_fill_prio     = prio_q[fill_id];
    assign bus.o_fill_count    = cnt_q[fill_id];
    assign bus.o_occupancy     = occ;

`ifdef FIBER_MSHR_STATS_EN
    logic [31:0] allocs_q, allocs_d;
    logic [31:0] merges_q, merges_d;

    // Wrapping counts of accepted allocations and merges
    always_comb begin
        allocs_d = allocs_q;
        merges_d = merges_q;
        if (miss_fire && hit) begin
            merges_d = merges_q + 32'd1;
        end
        if (miss_fire && !hit) begin
            allocs_d = allocs_q + 32'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            allocs_q <= '0;
            merges_q <= '0;
        end else begin
            allocs_q <= allocs_d;
            merges_q <= merges_d;
        end
    end

    assign bus.o_stat_allocs = allocs_q;
    assign bus.o_stat_merges = merges_q;
`else
    assign bus.o_stat_allocs = '0;
    assign bus.o_stat_merges = '0;
`endif
endmodule
